// File: rtl/sa_result_writeback.sv
// Drains one N-lane result vector from the systolic array into SPAD_Y port0, one word per cycle.
// Optional ReLU at capture is enabled by defining SA_WB_RELU_EN.
module sa_result_writeback #(
  parameter int N  = 4,
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            y_valid_i,
  input  logic [N*DW-1:0] y_in,
  input  logic [AW-1:0]   base_addr_y,
  output logic            y_ready_o,
  output logic            spad_y_csb0,
  output logic [AW-1:0]   spad_y_addr0,
  output logic [DW-1:0]   spad_y_din0,
  output logic            busy_o,
  output logic            done_o,
  output logic            overrun_o
);

  // Handshake: y_valid_i is a one-cycle pulse; it is accepted only in a cycle
  // where y_ready_o=1, otherwise the vector is dropped and overrun_o latches.
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q;
  logic [DW-1:0]   buf_q [N];
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   din_q;
  logic            csb_q;
  logic            overrun_q;
  logic            last_beat;

  assign last_beat = (idx_q == AW'(N - 1));

  function automatic logic [DW-1:0] wb_word(input logic [DW-1:0] w);
`ifdef SA_WB_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (y_valid_i) state_d = WRITE;
      WRITE:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Lane 0 goes straight to the data flop at capture so beat 0 lands in the
  // first cycle; the remaining lanes queue in buf_q and shift toward index 0.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      idx_q  <= '0;
      addr_q <= '0;
      din_q  <= '0;
      csb_q  <= 1'b1;
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (y_valid_i) begin
            for (int i = 0; i < N - 1; i++) buf_q[i] <= wb_word(y_in[(i+1)*DW +: DW]);
            buf_q[N-1] <= '0;
            idx_q  <= '0;
            addr_q <= base_addr_y;
            din_q  <= wb_word(y_in[DW-1:0]);
            csb_q  <= 1'b0;
          end
        end
        WRITE: begin
          if (last_beat) begin
            csb_q <= 1'b1;
          end else begin
            idx_q  <= idx_q + 1'b1;
            addr_q <= addr_q + 1'b1;
            din_q  <= buf_q[0];
            for (int i = 0; i < N - 1; i++) buf_q[i] <= buf_q[i+1];
            buf_q[N-1] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                             overrun_q <= 1'b0;
    else if (y_valid_i && state_q != IDLE) overrun_q <= 1'b1;
  end

  assign y_ready_o    = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign spad_y_csb0  = csb_q;
  assign spad_y_addr0 = addr_q;
  assign spad_y_din0  = din_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sa_result_writeback.sv
// Directed bench for sa_result_writeback: table of vectors plus reset, overrun and abort sequences.
module tb_sa_result_writeback;
  localparam int N  = 4;
  localparam int AW = 6;
  localparam int DW = 32;

  logic            clk;
  logic            n_rst;
  logic            y_valid_i;
  logic [N*DW-1:0] y_in;
  logic [AW-1:0]   base_addr_y;
  logic            y_ready_o;
  logic            spad_y_csb0;
  logic [AW-1:0]   spad_y_addr0;
  logic [DW-1:0]   spad_y_din0;
  logic            busy_o;
  logic            done_o;
  logic            overrun_o;

  int checks   = 0;
  int failures = 0;
  int beat_cnt = 0;
  int done_cnt = 0;

  logic [AW+DW-1:0] exp_q[$];

  typedef struct {
    logic [AW-1:0]          base;
    logic [N-1:0][DW-1:0]   y;
    logic [N-1:0][AW-1:0]   exp_addr;
    logic [N-1:0][DW-1:0]   exp_din;
  } vec_t;

  vec_t vecs[4];

  sa_result_writeback #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .n_rst(n_rst), .y_valid_i(y_valid_i), .y_in(y_in),
    .base_addr_y(base_addr_y), .y_ready_o(y_ready_o), .spad_y_csb0(spad_y_csb0),
    .spad_y_addr0(spad_y_addr0), .spad_y_din0(spad_y_din0), .busy_o(busy_o),
    .done_o(done_o), .overrun_o(overrun_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every write beat seen on port0 must match the head of exp_q
  always @(negedge clk) begin
    if (done_o === 1'b1) done_cnt++;
    if (spad_y_csb0 === 1'b0) begin
      beat_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_write: got addr %h data %h expected no write", spad_y_addr0, spad_y_din0);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({spad_y_addr0, spad_y_din0} !== e) begin
          failures++;
          $display("FAIL sb_write: got %h expected %h", {spad_y_addr0, spad_y_din0}, e);
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
    for (int k = 0; k < N; k++) exp_q.push_back({v.exp_addr[k], v.exp_din[k]});
  endtask

  // drive one vector and check the full timing of its write-back
  task automatic run_vec(input vec_t v, input string tag);
    int d0;
    @(negedge clk);
    chk({tag, "_ready_before"}, 64'(y_ready_o), 64'd1);
    push_exp(v);
    d0 = done_cnt;
    y_valid_i = 1'b1; y_in = v.y; base_addr_y = v.base;
    @(negedge clk);
    y_valid_i = 1'b0; y_in = {N{32'hDEADBEEF}}; base_addr_y = AW'($urandom_range(0, 63));
    for (int k = 0; k < N; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, "_csb"}, 64'(spad_y_csb0), 64'd0);
      chk({tag, "_addr"}, 64'(spad_y_addr0), 64'(v.exp_addr[k]));
      chk({tag, "_din"}, 64'(spad_y_din0), 64'(v.exp_din[k]));
      chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    end
    @(negedge clk);
    chk({tag, "_done"}, 64'(done_o), 64'd1);
    chk({tag, "_done_csb"}, 64'(spad_y_csb0), 64'd1);
    chk({tag, "_done_ready"}, 64'(y_ready_o), 64'd0);
    @(negedge clk);
    chk({tag, "_ready_after"}, 64'(y_ready_o), 64'd1);
    chk({tag, "_done_after"}, 64'(done_o), 64'd0);
    chk({tag, "_hold_addr"}, 64'(spad_y_addr0), 64'(v.exp_addr[N-1]));
    chk({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int b0, d0;
    vec_t v;

    vecs[0].base = 6'h10;
    vecs[0].y        = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    vecs[0].exp_addr = {6'h13, 6'h12, 6'h11, 6'h10};
    vecs[0].exp_din  = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
    vecs[1].base = 6'd62;
    vecs[1].y        = {32'h11110004, 32'h11110003, 32'h11110002, 32'h11110001};
    vecs[1].exp_addr = {6'd1, 6'd0, 6'd63, 6'd62};
    vecs[1].exp_din  = {32'h11110004, 32'h11110003, 32'h11110002, 32'h11110001};
    vecs[2].base = 6'h20;
    vecs[2].y        = {32'h7F7FFFFF, 32'h3F800000, 32'h80000000, 32'hBF800000};
    vecs[2].exp_addr = {6'h23, 6'h22, 6'h21, 6'h20};
`ifdef SA_WB_RELU_EN
    vecs[2].exp_din  = {32'h7F7FFFFF, 32'h3F800000, 32'h00000000, 32'h00000000};
`else
    vecs[2].exp_din  = {32'h7F7FFFFF, 32'h3F800000, 32'h80000000, 32'hBF800000};
`endif
    vecs[3].base = 6'd63;
    vecs[3].y        = {32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 32'hA5A5A5A5};
    vecs[3].exp_addr = {6'd2, 6'd1, 6'd0, 6'd63};
`ifdef SA_WB_RELU_EN
    vecs[3].exp_din  = {32'h00000000, 32'h00000000, 32'h0000FFFF, 32'h00000000};
`else
    vecs[3].exp_din  = {32'h00000000, 32'hFFFF0000, 32'h0000FFFF, 32'hA5A5A5A5};
`endif

    // reset values
    n_rst = 1'b0; y_valid_i = 1'b0; y_in = '0; base_addr_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_csb", 64'(spad_y_csb0), 64'd1);
    chk("rst_addr", 64'(spad_y_addr0), 64'd0);
    chk("rst_din", 64'(spad_y_din0), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_overrun", 64'(overrun_o), 64'd0);
    chk("rst_ready", 64'(y_ready_o), 64'd1);
    n_rst = 1'b1;
    b0 = beat_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_csb", 64'(spad_y_csb0), 64'd1);
    end
    chk("idle_no_writes", 64'(beat_cnt - b0), 64'd0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    chk("overrun_clear", 64'(overrun_o), 64'd0);

    // second valid during WRITE: dropped, overrun sticks, first vector intact
    v = vecs[0];
    push_exp(v);
    b0 = beat_cnt; d0 = done_cnt;
    @(negedge clk);
    y_valid_i = 1'b1; y_in = v.y; base_addr_y = v.base;
    @(negedge clk);
    y_valid_i = 1'b0;
    @(negedge clk);
    y_valid_i = 1'b1; y_in = {N{32'hCAFEF00D}}; base_addr_y = 6'h30;
    @(negedge clk);
    y_valid_i = 1'b0;
    chk("ovr_set", 64'(overrun_o), 64'd1);
    repeat (6) @(negedge clk);
    chk("ovr_beats", 64'(beat_cnt - b0), 64'd4);
    chk("ovr_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("ovr_sb_drained", 64'(exp_q.size()), 64'd0);
    run_vec(vecs[2], "post_ovr");
    chk("ovr_sticky", 64'(overrun_o), 64'd1);

    // reset after beat 1 aborts at once
    v = vecs[1];
    push_exp(v);
    b0 = beat_cnt;
    @(negedge clk);
    y_valid_i = 1'b1; y_in = v.y; base_addr_y = v.base;
    @(negedge clk);
    y_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_beat1_addr", 64'(spad_y_addr0), 64'd63);
    @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    chk("abort_csb", 64'(spad_y_csb0), 64'd1);
    chk("abort_busy", 64'(busy_o), 64'd0);
    chk("abort_overrun", 64'(overrun_o), 64'd0);
    repeat (2) @(negedge clk);
    chk("abort_beats", 64'(beat_cnt - b0), 64'd2);
    chk("abort_leftover", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    n_rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 64'(y_ready_o), 64'd1);
    run_vec(vecs[0], "post_abort");

    repeat (2) @(negedge clk);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
